// File: rtl/alarm_pkg.sv
// alarm_pkg: shared beeper state type and default board timing
package alarm_pkg;
  typedef enum logic [1:0] {IDLE, ON, OFF} beeper_state_t;
  localparam int DEF_TONE_HALF = 2;
  localparam int DEF_BEEP_ON = 8;
  localparam int DEF_BEEP_OFF = 4;
  localparam int DEF_NUM_BEEPS = 3;
  localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/alarm_beeper_tone_gen.sv
// tone_gen: square-wave tone flop; restart forces a fresh high half-period, !en silences
module tone_gen #(
  parameter int TONE_HALF = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic tone
);
  logic [CNT_W-1:0] tc;
  always_ff @(posedge clk) begin
    if (rst || !(en || restart)) begin
      tc <= '0;
      tone <= 1'b0;
    end else if (restart) begin
      tc <= '0;
      tone <= 1'b1;
    end else if (tc == CNT_W'(TONE_HALF - 1)) begin
      tc <= '0;
      tone <= ~tone;
    end else begin
      tc <= tc + 1'b1;
    end
  end
endmodule

// File: rtl/alarm_beeper.sv
// alarm_beeper: start pulse launches NUM_BEEPS tone bursts; stop aborts (ALARM_BEEPER_RETRIGGER_EN: start restarts a running pattern)
module alarm_beeper
  import alarm_pkg::*;
#(
  parameter int TONE_HALF = DEF_TONE_HALF,
  parameter int BEEP_ON = DEF_BEEP_ON,
  parameter int BEEP_OFF = DEF_BEEP_OFF,
  parameter int NUM_BEEPS = DEF_NUM_BEEPS,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic buzzer,
  output logic active,
  output logic done
);
  localparam int BC_W = $clog2(NUM_BEEPS + 1);
`ifdef ALARM_BEEPER_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  beeper_state_t state, state_n;
  logic [CNT_W-1:0] ph, ph_n;
  logic [BC_W-1:0] bc, bc_n;
  logic restart, en, active_n, done_n, last_beep;
  assign last_beep = bc == BC_W'(NUM_BEEPS);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph <= '0;
      bc <= '0;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      bc <= bc_n;
      active <= active_n;
      done <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    ph_n = ph + 1'b1;
    bc_n = bc;
    restart = 1'b0;
    if (stop) begin
      state_n = IDLE;
      ph_n = '0;
      bc_n = '0;
    end else if (start && (state == IDLE || RETRIG)) begin
      state_n = ON;
      ph_n = '0;
      bc_n = BC_W'(1);
      restart = 1'b1;
    end else if (state == IDLE) begin
      ph_n = '0;
    end else if (state == ON && ph == CNT_W'(BEEP_ON - 1)) begin
      state_n = OFF;
      ph_n = '0;
    end else if (state == OFF && ph == CNT_W'(BEEP_OFF - 1)) begin
      state_n = last_beep ? IDLE : ON;
      ph_n = '0;
      bc_n = last_beep ? '0 : bc + 1'b1;
      restart = !last_beep;
    end
  end
  // only an unaborted OFF->IDLE exit counts as completion
  always_comb begin
    en = state_n == ON;
    active_n = state_n != IDLE;
    done_n = state == OFF && state_n == IDLE && !stop;
  end
  tone_gen #(.TONE_HALF(TONE_HALF), .CNT_W(CNT_W)) u_tone (
    .clk(clk),
    .rst(rst),
    .en(en),
    .restart(restart),
    .tone(buzzer)
  );
endmodule
